// File: rtl/bilinear_step_ctrl_if.sv
// ---------------------------------------------------------------------------
// bilinear_step_ctrl_if
// Output entry stream from the bilinear step sequencer to the interpolation
// MAC. One entry carries the source index pair and the table dx. The
// coefficient ROM output is aligned with this stream.
//
// Signals:
//   out_valid    entry presented (coe0/coe1 valid in the same cycle)
//   out_ready    consumer accepts the presented entry
//   out_idx      left source pixel index
//   out_idx_nxt  right source pixel index (clamped to the last pixel)
//   out_dx       coefficient-table address of the presented entry
//   out_last     final entry of the line
//
// Modports: master = sequencer, slave = interpolation datapath.
// ---------------------------------------------------------------------------
interface bilinear_step_ctrl_if #(
    parameter int unsigned INT_W = 12,
    parameter int unsigned DX_W  = 10
);
    logic             out_valid;
    logic             out_ready;
    logic [INT_W-1:0] out_idx;
    logic [INT_W-1:0] out_idx_nxt;
    logic [DX_W-1:0]  out_dx;
    logic             out_last;

    modport master (
        output out_valid,
        output out_idx,
        output out_idx_nxt,
        output out_dx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_idx_nxt,
        input  out_dx,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/bilinear_step_ctrl.sv
// ---------------------------------------------------------------------------
// bilinear_step_ctrl
// Per-line phase sequencer for the horizontal bilinear scaler. Walks a
// saturating phase accumulator across the line, emits one source index pair
// per output pixel and addresses the registered (1-cycle) coefficient ROM so
// that coe0/coe1 line up with the presented entry.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start            1-cycle pulse, begins a line (only accepted in IDLE)
//   scale            source step per output pixel, Q INT_W.FRAC_W
//   init_phase       starting source position, Q INT_W.FRAC_W
//   src_width        source pixels in the line (>= 1)
//   dst_width        output pixels to generate (0 -> immediate done)
//   tbl_dx           coefficient ROM address (combinational)
//   busy             not IDLE
//   done             1-cycle pulse after the last transfer
//   stall_cnt        cycles with out_valid & ~out_ready in the current line
//   out_if           output entry stream (master modport)
//
// Build option: BILINEAR_STEP_CTRL_STALL_STATS_EN enables the stall counter;
// without it stall_cnt is tied to zero.
//
// state | meaning
// IDLE  | waiting for start, params may change freely
// RUN   | loading one entry per advance from the accumulator
// FLUSH | last entry loaded, waiting for its transfer
// ---------------------------------------------------------------------------
module bilinear_step_ctrl #(
    parameter int unsigned STEP   = 4096,
    parameter int unsigned FRAC_W = $clog2(STEP),
    parameter int unsigned DX_W   = $clog2(STEP / 4),
    parameter int unsigned INT_W  = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [INT_W+FRAC_W-1:0] scale,
    input  logic [INT_W+FRAC_W-1:0] init_phase,
    input  logic [INT_W-1:0]        src_width,
    input  logic [INT_W-1:0]        dst_width,
    output logic [DX_W-1:0]         tbl_dx,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             stall_cnt,
    bilinear_step_ctrl_if.master    out_if
);

    localparam int unsigned ACC_W = INT_W + FRAC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [INT_W-1:0]        cnt_q, cnt_d;
    logic [INT_W+FRAC_W-1:0] scale_q, scale_d;
    logic [INT_W-1:0]        src_w_q, src_w_d;
    logic [INT_W-1:0]        dst_w_q, dst_w_d;
    logic                    valid_q, valid_d;
    logic [INT_W-1:0]        idx_q, idx_d;
    logic [INT_W-1:0]        idx_nxt_q, idx_nxt_d;
    logic [DX_W-1:0]         dx_q, dx_d;
    logic                    last_q, last_d;
    logic                    done_q, done_d;

    logic                    adv;
    logic [INT_W:0]          acc_int;
    logic [DX_W-1:0]         acc_dx;
    logic [INT_W-1:0]        src_last;
    logic [INT_W-1:0]        idx_calc;
    logic [INT_W-1:0]        idx_nxt_calc;
    logic [ACC_W:0]          acc_sum;
    logic [ACC_W-1:0]        acc_inc;

    assign adv      = out_if.out_ready | ~valid_q;
    assign acc_int  = acc_q[ACC_W-1:FRAC_W];
    assign acc_dx   = acc_q[FRAC_W-1 -: DX_W];
    assign src_last = src_w_q - INT_W'(1);

    // acc_int carries one extra bit, so a saturated accumulator still clamps.
    assign idx_calc     = (acc_int >= {1'b0, src_w_q}) ? src_last : acc_int[INT_W-1:0];
    assign idx_nxt_calc = (idx_calc >= src_last) ? src_last : idx_calc + INT_W'(1);

    // Saturate at all-ones instead of wrapping back to the line start.
    assign acc_sum = {1'b0, acc_q} + {2'b00, scale_q};
    assign acc_inc = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];

    // When the output register will not load, keep the ROM on the presented
    // entry so coe0/coe1 stay valid through a stall.
    assign tbl_dx = adv ? acc_dx : dx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            scale_q   <= '0;
            src_w_q   <= '0;
            dst_w_q   <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            idx_nxt_q <= '0;
            dx_q      <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            scale_q   <= scale_d;
            src_w_q   <= src_w_d;
            dst_w_q   <= dst_w_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            idx_nxt_q <= idx_nxt_d;
            dx_q      <= dx_d;
            last_q    <= last_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        scale_d   = scale_q;
        src_w_d   = src_w_q;
        dst_w_d   = dst_w_q;
        valid_d   = valid_q;
        idx_d     = idx_q;
        idx_nxt_d = idx_nxt_q;
        dx_d      = dx_q;
        last_d    = last_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    scale_d = scale;
                    src_w_d = src_width;
                    dst_w_d = dst_width;
                    acc_d   = {1'b0, init_phase};
                    cnt_d   = '0;
                    if (dst_width == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (adv) begin
                    valid_d   = 1'b1;
                    idx_d     = idx_calc;
                    idx_nxt_d = idx_nxt_calc;
                    dx_d      = acc_dx;
                    last_d    = (cnt_q == dst_w_q - INT_W'(1));
                    acc_d     = acc_inc;
                    cnt_d     = cnt_q + INT_W'(1);
                    if (cnt_q == dst_w_q - INT_W'(1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (out_if.out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    assign out_if.out_valid   = valid_q;
    assign out_if.out_idx     = idx_q;
    assign out_if.out_idx_nxt = idx_nxt_q;
    assign out_if.out_dx      = dx_q;
    assign out_if.out_last    = last_q;
    assign busy               = (state_q != IDLE);
    assign done               = done_q;

`ifdef BILINEAR_STEP_CTRL_STALL_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && start) begin
            stall_d = '0;
        end else if (valid_q && !out_if.out_ready && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: doc/bilinear_step_ctrl.md
Name: bilinear_step_ctrl

Overview:
- Per-line phase sequencer for the horizontal bilinear scaler.
- For each output pixel it generates the source pixel index pair and the coefficient-table address, and drives the bilinear coefficient ROM (registered, 1-cycle read).
- Index outputs are time-aligned with the ROM's coe0/coe1, under a valid/ready handshake toward the interpolation MAC.
- Sits between the line control FSM (start/params) and the interpolation datapath.

Parameters:
- STEP, 4096, phase units per source pixel; power of 2.
- FRAC_W, $clog2(STEP), fractional bits of the phase accumulator.
- DX_W, $clog2(STEP/4), coefficient-table address width; dx = acc_frac[FRAC_W-1 -: DX_W].
- INT_W, 12, pixel index and width field width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  1-cycle pulse, begin a line; ignored unless IDLE
- scale  in  INT_W+FRAC_W  source step per output pixel (Q INT_W.FRAC_W); sampled on start
- init_phase  in  INT_W+FRAC_W  starting source position; sampled on start
- src_width  in  INT_W  source pixels in line (>=1); sampled on start
- dst_width  in  INT_W  output pixels to generate; sampled on start
- tbl_dx  out  DX_W  address to the coefficient ROM (combinational)
- out_valid  out  1  output entry valid; coe0/coe1 valid in same cycle
- out_ready  in  1  downstream accepts entry
- out_idx  out  INT_W  left source pixel index
- out_idx_nxt  out  INT_W  right source pixel index, min(out_idx+1, src_width-1)
- out_dx  out  DX_W  dx of the presented entry (debug/alignment)
- out_last  out  1  last entry of line
- busy  out  1  not IDLE
- done  out  1  1-cycle pulse after the last handshake, or after start with dst_width=0
- stall_cnt  out  16  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; out_valid, out_last, busy, done = 0.
  - out_idx, out_idx_nxt, out_dx, internal accumulator/counter = 0.
  - stall_cnt = 0.
  - Reset mid-line aborts the line with no done pulse.
- Handshake:
  - adv = out_ready | ~out_valid.
  - An entry transfers when out_valid & out_ready.
  - While out_valid & ~out_ready, all out_* hold stable.
- Table alignment:
  - tbl_dx = adv ? acc-derived dx of the next entry : out_dx.
  - The ROM register therefore always holds coe for the presented entry.
  - Latency from accumulator to out_* and coe0/coe1 is 1 cycle.
- FSM:
  - IDLE: on start, latch params, acc=init_phase, cnt=0.
    - If dst_width==0: done=1 next cycle, stay IDLE.
    - Otherwise go to RUN.
  - RUN: each cycle with adv=1, load the output register from acc:
    - idx=min(acc_int, src_width-1); idx_nxt=min(idx+1, src_width-1).
    - out_dx=acc_frac>>2; out_last=(cnt==dst_width-1); out_valid=1.
    - Then acc+=scale, cnt++.
    - After loading the last entry go to FLUSH.
  - FLUSH: on transfer of the last entry, out_valid=0, done=1 for 1 cycle, go to IDLE.
- Accumulator:
  - Width INT_W+FRAC_W+1; saturates at all-ones (no wrap).
  - Integer part >= src_width clamps as above; out_dx is still taken from acc_frac when clamping.
- Bubble-free: with out_ready held at 1, one entry per cycle. First out_valid appears 1 cycle after leaving IDLE; done follows the last entry by 1 cycle.
- start while busy is ignored; param inputs are don't-care except on accepted start.

Optional Feature:
- Macro BILINEAR_STEP_CTRL_STALL_STATS_EN.
- Defined:
  - stall_cnt clears on accepted start.
  - stall_cnt increments by 1 each cycle out_valid & ~out_ready, saturating at 0xFFFF.
  - Value holds after done until the next start.
- Undefined: stall_cnt is tied to 0 and no counter logic is inferred; the port remains.

Test Plan:
- 2x downscale: scale=8192, init=0, src=8, dst=4, out_ready=1 -> idx 0,2,4,6; idx_nxt 1,3,5,7; dx 0 each; last on 4th; done 1 cycle later; 4 consecutive valid cycles.
- 2x upscale: scale=2048, src=4, dst=4 -> idx 0,0,1,1; dx 0,512,0,512; coe0/coe1 match ROM[dx] in the same cycle.
- Edge clamp: scale=4096, src=2, dst=4 -> idx 0,1,1,1; idx_nxt 1,1,1,1.
- Backpressure: upscale case with out_ready low for 3 cycles at entry 2 -> out_* and coe hold; tbl_dx=512 during stall; sequence is unchanged; with the macro, stall_cnt=3.
- dst_width=0 -> no out_valid; done pulses 1 cycle after start; busy stays 0. A start during RUN is ignored.
- Reset mid-line after 2 entries -> all outputs 0 next cycle, no done; a new start then produces the full sequence from init_phase.
